dcache_controller: RTL and testbench

//  Direct-mapped, write-back, write-allocate data cache with its miss-handling FSM.

---
 rtl/cache_pkg.sv | 49 ++++
 rtl/dcache_controller_if.sv | 51 +++++
 rtl/dcache_array.sv | 65 ++++++
 rtl/dcache_controller.sv | 153 +++++++++++++++
 tb/tb_dcache_controller.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
// Shared cache definitions: geometry, address field positions, FSM state
// encoding and address field extraction helpers. Intended to be reused by
// the instruction cache as well.
// ---------------------------------------------------------------------------
package cache_pkg;

    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned INDEX_W    = 3;
    localparam int unsigned OFFSET_W   = 2;
    localparam int unsigned TAG_W      = ADDR_W - INDEX_W - OFFSET_W;
    localparam int unsigned NUM_BLOCKS = 1 << INDEX_W;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned BLOCK_W    = BYTE_W << OFFSET_W;
    localparam int unsigned MEM_ADDR_W = TAG_W + INDEX_W;

    // Field positions inside a CPU byte address {tag, index, offset}
    localparam int unsigned OFFSET_LSB = 0;
    localparam int unsigned INDEX_LSB  = OFFSET_W;
    localparam int unsigned TAG_LSB    = OFFSET_W + INDEX_W;

    typedef logic [ADDR_W-1:0]     addr_t;
    typedef logic [TAG_W-1:0]      tag_t;
    typedef logic [INDEX_W-1:0]    index_t;
    typedef logic [OFFSET_W-1:0]   offset_t;
    typedef logic [BYTE_W-1:0]     byte_t;
    typedef logic [BLOCK_W-1:0]    block_t;
    typedef logic [MEM_ADDR_W-1:0] mem_addr_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MEM_WB = 2'd1,
        MEM_RD = 2'd2
    } cache_state_e;

    function automatic tag_t addr_tag(input addr_t a);
        return a[TAG_LSB +: TAG_W];
    endfunction

    function automatic index_t addr_index(input addr_t a);
        return a[INDEX_LSB +: INDEX_W];
    endfunction

    function automatic offset_t addr_offset(input addr_t a);
        return a[OFFSET_LSB +: OFFSET_W];
    endfunction

endpackage

// File: rtl/dcache_controller_if.sv
// ---------------------------------------------------------------------------
// dcache_cpu_if : CPU load/store port of the data cache.
//   READ/WRITE/ADDRESS/WRITEDATA  CPU -> cache (level requests)
//   READDATA/BUSYWAIT             cache -> CPU
//   master = CPU side, slave = cache side.
// dcache_mem_if : block-transfer port between the cache and data memory.
//   MEM_READ/MEM_WRITE/MEM_ADDRESS/MEM_WRITEDATA  cache -> memory
//   MEM_READDATA/MEM_BUSYWAIT                     memory -> cache
//   master = cache side, slave = memory side.
// ---------------------------------------------------------------------------
interface dcache_cpu_if;
    import cache_pkg::*;

    logic  READ;
    logic  WRITE;
    addr_t ADDRESS;
    byte_t WRITEDATA;
    byte_t READDATA;
    logic  BUSYWAIT;

    modport master (
        output READ, WRITE, ADDRESS, WRITEDATA,
        input  READDATA, BUSYWAIT
    );

    modport slave (
        input  READ, WRITE, ADDRESS, WRITEDATA,
        output READDATA, BUSYWAIT
    );
endinterface

interface dcache_mem_if;
    import cache_pkg::*;

    logic      MEM_READ;
    logic      MEM_WRITE;
    mem_addr_t MEM_ADDRESS;
    block_t    MEM_WRITEDATA;
    block_t    MEM_READDATA;
    logic      MEM_BUSYWAIT;

    modport master (
        output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
        input  MEM_READDATA, MEM_BUSYWAIT
    );

    modport slave (
        input  MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
        output MEM_READDATA, MEM_BUSYWAIT
    );
endinterface

// File: rtl/dcache_array.sv
// ---------------------------------------------------------------------------
// dcache_array
// Direct-mapped storage: per-block data, tag, valid and dirty bits.
//   clk_i, rst_ni   clock, synchronous active-low clear of valid/dirty
//   index_i         block selected for all reads and writes
//   offset_i        byte lane for byte writes
//   byte_we_i       write byte_i into the selected lane, mark block dirty
//   fill_i          load fill_data_i/fill_tag_i, mark valid and clean
//   clean_i         clear dirty (victim written back)
//   tag_o, valid_o, dirty_o, block_o  combinational read of block index_i
// Data and tags are not reset; valid gates their use.
// ---------------------------------------------------------------------------
module dcache_array
    import cache_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_ni,
    input  index_t index_i,
    input  offset_t offset_i,
    input  logic   byte_we_i,
    input  byte_t  byte_i,
    input  logic   fill_i,
    input  tag_t   fill_tag_i,
    input  block_t fill_data_i,
    input  logic   clean_i,
    output tag_t   tag_o,
    output logic   valid_o,
    output logic   dirty_o,
    output block_t block_o
);

    logic [NUM_BLOCKS-1:0] valid_q;
    logic [NUM_BLOCKS-1:0] dirty_q;
    tag_t                  tag_q  [NUM_BLOCKS];
    block_t                data_q [NUM_BLOCKS];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_i) begin
            valid_q[index_i] <= 1'b1;
            dirty_q[index_i] <= 1'b0;
        end else if (byte_we_i) begin
            dirty_q[index_i] <= 1'b1;
        end else if (clean_i) begin
            dirty_q[index_i] <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fill_i) begin
            data_q[index_i] <= fill_data_i;
            tag_q[index_i]  <= fill_tag_i;
        end else if (byte_we_i) begin
            data_q[index_i][offset_i*BYTE_W +: BYTE_W] <= byte_i;
        end
    end

    assign tag_o   = tag_q[index_i];
    assign valid_o = valid_q[index_i];
    assign dirty_o = dirty_q[index_i];
    assign block_o = data_q[index_i];

endmodule

// File: rtl/dcache_controller.sv
// ---------------------------------------------------------------------------
// dcache_controller
// Direct-mapped, write-back, write-allocate data cache. Hits complete in the
// request cycle; misses stall the CPU with BUSYWAIT while the FSM writes back
// a dirty victim (MEM_WB) and refills the block (MEM_RD), after which the
// request completes as a hit in IDLE.
//   CLK    clock
//   RESET  synchronous active-low reset
//   cpu    CPU load/store port (READ/WRITE/ADDRESS/WRITEDATA, READDATA/BUSYWAIT)
//   mem    block memory port (MEM_READ/MEM_WRITE/MEM_ADDRESS/MEM_WRITEDATA,
//          MEM_READDATA/MEM_BUSYWAIT)
// ---------------------------------------------------------------------------
module dcache_controller
    import cache_pkg::*;
(
    input  logic         CLK,
    input  logic         RESET,
    dcache_cpu_if.slave  cpu,
    dcache_mem_if.master mem
);

    cache_state_e state_q, state_d;
    logic         mem_read_q, mem_read_d;
    logic         mem_write_q, mem_write_d;
    mem_addr_t    mem_addr_q, mem_addr_d;
    block_t       mem_wdata_q, mem_wdata_d;

    tag_t    req_tag;
    index_t  req_index;
    offset_t req_offset;
    logic    req;
    logic    hit;

    tag_t   line_tag;
    logic   line_valid;
    logic   line_dirty;
    block_t line_data;

    logic byte_we;
    logic fill;
    logic clean;

    assign req_tag    = addr_tag(cpu.ADDRESS);
    assign req_index  = addr_index(cpu.ADDRESS);
    assign req_offset = addr_offset(cpu.ADDRESS);
    assign req        = cpu.READ | cpu.WRITE;
    assign hit        = line_valid && (line_tag == req_tag);

    dcache_array u_array (
        .clk_i       (CLK),
        .rst_ni      (RESET),
        .index_i     (req_index),
        .offset_i    (req_offset),
        .byte_we_i   (byte_we),
        .byte_i      (cpu.WRITEDATA),
        .fill_i      (fill),
        .fill_tag_i  (req_tag),
        .fill_data_i (mem.MEM_READDATA),
        .clean_i     (clean),
        .tag_o       (line_tag),
        .valid_o     (line_valid),
        .dirty_o     (line_dirty),
        .block_o     (line_data)
    );

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q     <= IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        byte_we = 1'b0;
        fill    = 1'b0;
        clean   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        // READ wins when both are asserted: the store is dropped.
                        byte_we = cpu.WRITE && !cpu.READ;
                    end else if (line_dirty) begin
                        state_d = MEM_WB;
                    end else begin
                        state_d = MEM_RD;
                    end
                end
            end
            MEM_WB: begin
                if (!mem.MEM_BUSYWAIT) begin
                    clean   = 1'b1;
                    state_d = MEM_RD;
                end
            end
            MEM_RD: begin
                if (!mem.MEM_BUSYWAIT) begin
                    fill    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Storage must not change on a reset edge, even mid-transfer.
        if (!RESET) begin
            byte_we = 1'b0;
            fill    = 1'b0;
            clean   = 1'b0;
        end
    end

    // Memory request registers are loaded from the state being entered so
    // they rise with the state and hold steady for the whole transfer.
    always_comb begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        unique case (state_d)
            MEM_WB: begin
                mem_write_d = 1'b1;
                mem_addr_d  = {line_tag, req_index};
                mem_wdata_d = line_data;
            end
            MEM_RD: begin
                mem_read_d = 1'b1;
                mem_addr_d = {req_tag, req_index};
            end
            default: ;
        endcase
    end

    assign cpu.BUSYWAIT  = RESET && req && !(state_q == IDLE && hit);
    assign cpu.READDATA  = (RESET && hit) ? line_data[req_offset*BYTE_W +: BYTE_W] : '0;

    assign mem.MEM_READ      = mem_read_q;
    assign mem.MEM_WRITE     = mem_write_q;
    assign mem.MEM_ADDRESS   = mem_addr_q;
    assign mem.MEM_WRITEDATA = mem_wdata_q;

endmodule

// File: tb/tb_dcache_controller.sv
module tb_dcache_controller;
    import cache_pkg::*;

    localparam int unsigned MEM_LAT = 5;

    logic CLK;
    logic RESET;

    dcache_cpu_if cif ();
    dcache_mem_if mif ();

    dcache_controller dut (
        .CLK   (CLK),
        .RESET (RESET),
        .cpu   (cif),
        .mem   (mif)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        logic [31:0] w;
        case (i)
            8'h00:   w = 32'h44332211;
            8'h09:   w = 32'hDDCCBBAA;
            8'h38:   w = 32'h87654321;
            default: w = 32'h01010101 * i[7:0] ^ 32'h5A000000;
        endcase
        return w;
    endfunction

    // ---------------- memory (bench-owned) ----------------
    logic [31:0] mem_arr [64];
    int unsigned cnt;
    logic [5:0]  last_wb_addr, last_rd_addr;
    logic [31:0] last_wb_data;

    assign mif.MEM_BUSYWAIT = (mif.MEM_READ || mif.MEM_WRITE) && (cnt < MEM_LAT);
    assign mif.MEM_READDATA = mem_arr[mif.MEM_ADDRESS];

    always @(posedge CLK) begin
        if (mif.MEM_READ || mif.MEM_WRITE) begin
            if (!mif.MEM_BUSYWAIT) begin
                cnt <= 0;
                if (mif.MEM_WRITE) begin
                    mem_arr[mif.MEM_ADDRESS] <= mif.MEM_WRITEDATA;
                    last_wb_addr <= mif.MEM_ADDRESS;
                    last_wb_data <= mif.MEM_WRITEDATA;
                end else begin
                    last_rd_addr <= mif.MEM_ADDRESS;
                end
            end else begin
                cnt <= cnt + 1;
            end
        end else begin
            cnt <= 0;
        end
    end

    // ---------------- reference model ----------------
    // Cache contents plus a queue of pending block transfers for the current
    // miss; the head of the queue is the transfer that must be on the bus.
    typedef struct {
        bit          wb;
        logic [5:0]  addr;
        logic [31:0] data;
    } xfer_t;

    bit          mvalid [8];
    bit          mdirty [8];
    bit [2:0]    mtag   [8];
    logic [31:0] mdata  [8];
    logic [31:0] ref_mem [64];
    xfer_t       pend [$];

    always @(posedge CLK) begin
        logic [2:0] t, ix;
        logic [1:0] off;
        xfer_t x;
        t   = cif.ADDRESS[7:5];
        ix  = cif.ADDRESS[4:2];
        off = cif.ADDRESS[1:0];
        if (!RESET) begin
            for (int i = 0; i < 8; i++) begin
                mvalid[i] = 1'b0;
                mdirty[i] = 1'b0;
            end
            pend.delete();
        end else if (pend.size() != 0) begin
            if (!mif.MEM_BUSYWAIT) begin
                x = pend.pop_front();
                if (x.wb) begin
                    ref_mem[x.addr] = x.data;
                    mdirty[x.addr[2:0]] = 1'b0;
                end else begin
                    mdata[x.addr[2:0]]  = ref_mem[x.addr];
                    mtag[x.addr[2:0]]   = x.addr[5:3];
                    mvalid[x.addr[2:0]] = 1'b1;
                    mdirty[x.addr[2:0]] = 1'b0;
                end
            end
        end else if (cif.READ || cif.WRITE) begin
            if (mvalid[ix] && mtag[ix] == t) begin
                if (cif.WRITE && !cif.READ) begin
                    mdata[ix][off*8 +: 8] = cif.WRITEDATA;
                    mdirty[ix] = 1'b1;
                end
            end else begin
                if (mdirty[ix])
                    pend.push_back('{wb: 1'b1, addr: {mtag[ix], ix}, data: mdata[ix]});
                pend.push_back('{wb: 1'b0, addr: {t, ix}, data: 32'h0});
            end
        end
    end

    logic chk_en;

    always @(negedge CLK) begin
        logic [2:0] t, ix;
        logic [1:0] off;
        logic       mhit, e_busy, e_mr, e_mw;
        logic [7:0] e_rd;
        logic [5:0] e_ma;
        logic [31:0] e_wd;
        if (chk_en) begin
            t    = cif.ADDRESS[7:5];
            ix   = cif.ADDRESS[4:2];
            off  = cif.ADDRESS[1:0];
            mhit = mvalid[ix] && (mtag[ix] == t);
            e_busy = RESET && (cif.READ || cif.WRITE) && !(pend.size() == 0 && mhit);
            e_rd   = (RESET && mhit) ? mdata[ix][off*8 +: 8] : 8'h00;
            e_mr = 1'b0; e_mw = 1'b0; e_ma = 6'h00; e_wd = 32'h0;
            if (pend.size() != 0) begin
                e_mr = !pend[0].wb;
                e_mw = pend[0].wb;
                e_ma = pend[0].addr;
                e_wd = pend[0].wb ? pend[0].data : 32'h0;
            end
            check("BUSYWAIT",      {31'h0, cif.BUSYWAIT},  {31'h0, e_busy});
            check("READDATA",      {24'h0, cif.READDATA},  {24'h0, e_rd});
            check("MEM_READ",      {31'h0, mif.MEM_READ},  {31'h0, e_mr});
            check("MEM_WRITE",     {31'h0, mif.MEM_WRITE}, {31'h0, e_mw});
            check("MEM_ADDRESS",   {26'h0, mif.MEM_ADDRESS}, {26'h0, e_ma});
            check("MEM_WRITEDATA", mif.MEM_WRITEDATA, e_wd);
        end
    end

    // ---------------- stimulus ----------------
    task automatic op(input logic rd, input logic wr, input logic [7:0] a,
                      input logic [7:0] d, output int n, output logic [7:0] rdat);
        @(posedge CLK);
        #1;
        cif.READ      = rd;
        cif.WRITE     = wr;
        cif.ADDRESS   = a;
        cif.WRITEDATA = d;
        n = 0;
        @(negedge CLK);
        while (cif.BUSYWAIT === 1'b1 && n < 200) begin
            n++;
            @(negedge CLK);
        end
        if (n >= 200) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: BUSYWAIT still high after %0d cycles, addr %h", n, a);
        end
        rdat = cif.READDATA;
        @(posedge CLK);
        #1;
        cif.READ  = 1'b0;
        cif.WRITE = 1'b0;
    endtask

    int         n;
    logic [7:0] rdat;

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem_arr[i] = init_word(i);
            ref_mem[i] = init_word(i);
        end
        for (int i = 0; i < 8; i++) begin
            mvalid[i] = 1'b0;
            mdirty[i] = 1'b0;
            mtag[i]   = 3'd0;
            mdata[i]  = 32'h0;
        end
        cnt = 0;
        chk_en = 1'b0;
        RESET = 1'b0;
        cif.READ = 1'b0;
        cif.WRITE = 1'b0;
        cif.ADDRESS = 8'h00;
        cif.WRITEDATA = 8'h00;

        @(posedge CLK);
        #1;
        chk_en = 1'b1;
        cif.READ = 1'b1;          // request while in reset must not stall
        @(negedge CLK);
        check("reset_busywait", {31'h0, cif.BUSYWAIT}, 32'h0);
        check("reset_mem_read", {31'h0, mif.MEM_READ}, 32'h0);
        @(posedge CLK);
        #1;
        cif.READ = 1'b0;
        RESET = 1'b1;

        // 1: cold read miss, clean refill
        op(1'b1, 1'b0, 8'h00, 8'h00, n, rdat);
        check("t1_stall_cycles", n, 7);
        check("t1_readdata", {24'h0, rdat}, 32'h11);
        check("t1_refill_addr", {26'h0, last_rd_addr}, 32'h00);

        // 2: read hit
        op(1'b1, 1'b0, 8'h02, 8'h00, n, rdat);
        check("t2_stall_cycles", n, 0);
        check("t2_readdata", {24'h0, rdat}, 32'h33);

        // 3: store hit then conflicting read -> write-back + refill
        op(1'b0, 1'b1, 8'h01, 8'hAA, n, rdat);
        check("t3_store_stall", n, 0);
        op(1'b1, 1'b0, 8'hE1, 8'h00, n, rdat);
        check("t3_stall_cycles", n, 13);
        check("t3_wb_addr", {26'h0, last_wb_addr}, 32'h00);
        check("t3_wb_data", last_wb_data, 32'h4433AA11);
        check("t3_refill_addr", {26'h0, last_rd_addr}, 32'h38);
        check("t3_readdata", {24'h0, rdat}, 32'h43);

        // 4: store miss to clean block, later evicted by conflict
        op(1'b0, 1'b1, 8'h24, 8'h5C, n, rdat);
        check("t4_stall_cycles", n, 7);
        check("t4_refill_addr", {26'h0, last_rd_addr}, 32'h09);
        op(1'b1, 1'b0, 8'h64, 8'h00, n, rdat);
        check("t4_evict_stall", n, 13);
        check("t4_wb_addr", {26'h0, last_wb_addr}, 32'h09);
        check("t4_wb_data", last_wb_data, 32'hDDCCBB5C);

        // 5: reset during refill
        @(posedge CLK);
        #1;
        cif.READ = 1'b1;
        cif.ADDRESS = 8'h08;
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        check("t5_busy_in_reset", {31'h0, cif.BUSYWAIT}, 32'h0);
        @(negedge CLK);
        check("t5_mem_read_dropped", {31'h0, mif.MEM_READ}, 32'h0);
        @(posedge CLK);
        #1;
        cif.READ = 1'b0;
        RESET = 1'b1;
        op(1'b1, 1'b0, 8'hE1, 8'h00, n, rdat);
        check("t5_rehit_misses", n, 7);
        check("t5_readdata", {24'h0, rdat}, 32'h43);

        // 6: READ and WRITE together on a hit
        op(1'b1, 1'b0, 8'h03, 8'h00, n, rdat);
        check("t6_refill_stall", n, 7);
        check("t6_readdata", {24'h0, rdat}, 32'h44);
        op(1'b1, 1'b1, 8'h03, 8'hFF, n, rdat);
        check("t6_rw_stall", n, 0);
        check("t6_rw_readdata", {24'h0, rdat}, 32'h44);
        op(1'b1, 1'b0, 8'h03, 8'h00, n, rdat);
        check("t6_unchanged", {24'h0, rdat}, 32'h44);
        op(1'b1, 1'b0, 8'hE0, 8'h00, n, rdat);
        check("t6_still_clean", n, 7);
        check("t6_e0_readdata", {24'h0, rdat}, 32'h21);

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
